// File: rtl/pwm_config_sequencer_if.sv
// Write bus from the SPI register interface
// into the PWM configuration sequencer.
interface pwm_config_sequencer_if;
  logic       wr_valid;
  logic [6:0] wr_addr;
  logic [7:0] wr_data;

  modport master (
    output wr_valid,
    output wr_addr,
    output wr_data
  );

  modport slave (
    input wr_valid,
    input wr_addr,
    input wr_data
  );
endinterface

// File: rtl/pwm_config_sequencer.sv
// Shadow/active register sequencer for pwm_peripheral
// with period-aligned commit and duty ramp engine.
module pwm_config_sequencer #(
  parameter int CLK_DIV = 12
) (
  input  logic clk,
  input  logic rst_n,
  pwm_config_sequencer_if.slave wr,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       period_tick,
  output logic       busy,
  output logic       ramp_done
);

  localparam logic [10:0] DIV_TC = 11'(CLK_DIV);

  typedef enum logic {
    IDLE    = 1'b0,
    RAMPING = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [10:0] clk_cnt;
  logic [7:0]  per_cnt;
  logic        div_wrap;

  logic [7:0] sh_out_lo, sh_out_hi;
  logic [7:0] sh_pwm_lo, sh_pwm_hi;
  logic [7:0] sh_duty;
  logic [7:0] ramp_target, ramp_step;
  logic       commit_pending;

  logic       ctrl_wr;
  logic       commit_req, start_req, abort_req;
  logic [7:0] step_eff;
  logic [8:0] diff;
  logic       ramp_up;
  logic [7:0] ramp_next;
  logic       ramp_hit;
  logic       step_en;
  logic       apply_commit;

  // Replica of the peripheral's divider chain
  assign div_wrap    = (clk_cnt == DIV_TC);
  assign period_tick = div_wrap && (per_cnt == 8'hFF);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_cnt <= '0;
      per_cnt <= '0;
    end else if (div_wrap) begin
      clk_cnt <= '0;
      per_cnt <= per_cnt + 8'd1;
    end else begin
      clk_cnt <= clk_cnt + 11'd1;
    end
  end

  assign ctrl_wr    = wr.wr_valid && (wr.wr_addr == 7'h07);
  assign commit_req = ctrl_wr && wr.wr_data[0];
  assign start_req  = ctrl_wr && wr.wr_data[1];
  assign abort_req  = ctrl_wr && wr.wr_data[2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_out_lo   <= '0;
      sh_out_hi   <= '0;
      sh_pwm_lo   <= '0;
      sh_pwm_hi   <= '0;
      sh_duty     <= '0;
      ramp_target <= '0;
      ramp_step   <= '0;
    end else if (wr.wr_valid) begin
      unique case (1'b1)
        wr.wr_addr == 7'h00: sh_out_lo   <= wr.wr_data;
        wr.wr_addr == 7'h01: sh_out_hi   <= wr.wr_data;
        wr.wr_addr == 7'h02: sh_pwm_lo   <= wr.wr_data;
        wr.wr_addr == 7'h03: sh_pwm_hi   <= wr.wr_data;
        wr.wr_addr == 7'h04: sh_duty     <= wr.wr_data;
        wr.wr_addr == 7'h05: ramp_target <= wr.wr_data;
        wr.wr_addr == 7'h06: ramp_step   <= wr.wr_data;
        default: ;
      endcase
    end
  end

  // A COMMIT landing on a tick survives the clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      commit_pending <= 1'b0;
    end else if (commit_req) begin
      commit_pending <= 1'b1;
    end else if (abort_req || period_tick) begin
      commit_pending <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start_req) state_d = RAMPING;
      end
      RAMPING: begin
        if (abort_req) begin
          state_d = IDLE;
        end else if (start_req) begin
          state_d = RAMPING;
        end else if (step_en && ramp_hit) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    step_eff  = (ramp_step == 8'd0) ? 8'd1 : ramp_step;
    ramp_up   = (ramp_target > pwm_duty_cycle);
    diff      = ramp_up
              ? {1'b0, ramp_target} - {1'b0, pwm_duty_cycle}
              : {1'b0, pwm_duty_cycle} - {1'b0, ramp_target};
    ramp_next = pwm_duty_cycle;
    if (diff <= {1'b0, step_eff}) begin
      ramp_next = ramp_target;
    end else if (ramp_up) begin
      ramp_next = pwm_duty_cycle + step_eff;
    end else begin
      ramp_next = pwm_duty_cycle - step_eff;
    end
    ramp_hit     = (ramp_next == ramp_target);
    step_en      = (state_q == RAMPING) && period_tick
                && !abort_req && !start_req;
    apply_commit = period_tick && commit_pending;
    busy         = commit_pending || (state_q == RAMPING);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_reg_out_7_0  <= '0;
      en_reg_out_15_8 <= '0;
      en_reg_pwm_7_0  <= '0;
      en_reg_pwm_15_8 <= '0;
    end else if (apply_commit) begin
      en_reg_out_7_0  <= sh_out_lo;
      en_reg_out_15_8 <= sh_out_hi;
      en_reg_pwm_7_0  <= sh_pwm_lo;
      en_reg_pwm_15_8 <= sh_pwm_hi;
    end
  end

  // The ramp owns the duty while running
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_duty_cycle <= '0;
    end else if (step_en) begin
      pwm_duty_cycle <= ramp_next;
    end else if (apply_commit && state_q != RAMPING) begin
      pwm_duty_cycle <= sh_duty;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ramp_done <= 1'b0;
    end else begin
      ramp_done <= step_en && ramp_hit;
    end
  end

endmodule

// File: tb/tb_pwm_config_sequencer.sv
// Directed scoreboard bench for pwm_config_sequencer
// with a short divider (period of 256 clocks).
module tb_pwm_config_sequencer;

  logic clk;
  logic rst_n;
  logic [7:0] en_out_lo, en_out_hi;
  logic [7:0] en_pwm_lo, en_pwm_hi;
  logic [7:0] duty;
  logic tick, busy, done;

  pwm_config_sequencer_if wr_bus ();

  pwm_config_sequencer #(.CLK_DIV(0)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .wr              (wr_bus.slave),
    .en_reg_out_7_0  (en_out_lo),
    .en_reg_out_15_8 (en_out_hi),
    .en_reg_pwm_7_0  (en_pwm_lo),
    .en_reg_pwm_15_8 (en_pwm_hi),
    .pwm_duty_cycle  (duty),
    .period_tick     (tick),
    .busy            (busy),
    .ramp_done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int checks;
  int failures;

  task automatic expect_v(input string tag,
                          input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $error("FAIL sb_empty got=0x%0h exp=entry", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        failures++;
        $error("FAIL %s got=0x%0h exp=0x%0h",
               e.tag, obs, e.val);
      end
    end
  endtask

  task automatic wr(input logic [6:0] a,
                    input logic [7:0] d);
    @(negedge clk);
    wr_bus.wr_valid = 1'b1;
    wr_bus.wr_addr  = a;
    wr_bus.wr_data  = d;
    @(negedge clk);
    wr_bus.wr_valid = 1'b0;
  endtask

  // Leaves us at the negedge of the tick cycle
  task automatic wait_tick();
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 600 && !seen; n++) begin
      @(negedge clk);
      if (tick) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      failures++;
      $error("FAIL tick_timeout got=none exp=tick");
    end
  endtask

  task automatic tick_and_settle();
    wait_tick();
    @(negedge clk);
  endtask

  task automatic set_duty(input logic [7:0] d);
    wr(7'h04, d);
    wr(7'h07, 8'h01);
    tick_and_settle();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    wr_bus.wr_valid = 1'b0;
    wr_bus.wr_addr  = '0;
    wr_bus.wr_data  = '0;
    repeat (3) @(negedge clk);

    expect_v("rst_out_lo", 0); chk(en_out_lo);
    expect_v("rst_pwm_hi", 0); chk(en_pwm_hi);
    expect_v("rst_duty", 0);   chk(duty);
    expect_v("rst_busy", 0);   chk(busy);
    expect_v("rst_done", 0);   chk(done);
    expect_v("rst_tick", 0);   chk(tick);

    // Shadow writes without commit
    rst_n = 1'b1;
    wr(7'h00, 8'hFF);
    wr(7'h04, 8'h80);
    wr(7'h08, 8'h55);
    expect_v("t1_tick0", 255);
    wait_tick(); chk(cyc);
    @(negedge clk);
    expect_v("t1_out_lo", 0); chk(en_out_lo);
    expect_v("t1_duty", 0);   chk(duty);
    expect_v("t1_busy", 0);   chk(busy);
    expect_v("t1_tick1", 511);
    wait_tick(); chk(cyc);

    // Commit lands on the period boundary
    wr(7'h00, 8'h0F);
    wr(7'h02, 8'h05);
    wr(7'h04, 8'h40);
    wr(7'h07, 8'h01);
    expect_v("t2_busy_set", 1); chk(busy);
    expect_v("t2_out_early", 0); chk(en_out_lo);
    wait_tick();
    expect_v("t2_duty_pre", 0); chk(duty);
    @(negedge clk);
    expect_v("t2_out_lo", 8'h0F); chk(en_out_lo);
    expect_v("t2_pwm_lo", 8'h05); chk(en_pwm_lo);
    expect_v("t2_duty", 8'h40);   chk(duty);
    expect_v("t2_busy_clr", 0);   chk(busy);

    // Ramp up in steps of 0x0C
    set_duty(8'h10);
    expect_v("t3_base", 8'h10); chk(duty);
    wr(7'h05, 8'h30);
    wr(7'h06, 8'h0C);
    wr(7'h07, 8'h02);
    expect_v("t3_busy", 1); chk(busy);
    tick_and_settle();
    expect_v("t3_s1", 8'h1C); chk(duty);
    expect_v("t3_nodone", 0); chk(done);
    tick_and_settle();
    expect_v("t3_s2", 8'h28); chk(duty);
    tick_and_settle();
    expect_v("t3_s3", 8'h30); chk(duty);
    expect_v("t3_done", 1);   chk(done);
    expect_v("t3_idle", 0);   chk(busy);
    @(negedge clk);
    expect_v("t3_done_pulse", 0); chk(done);

    // Saturating top end
    set_duty(8'hF8);
    wr(7'h05, 8'hFF);
    wr(7'h06, 8'h10);
    wr(7'h07, 8'h02);
    tick_and_settle();
    expect_v("t4_top", 8'hFF); chk(duty);
    expect_v("t4_top_done", 1); chk(done);

    // Step 0 behaves as step 1, down to zero
    set_duty(8'h05);
    wr(7'h05, 8'h00);
    wr(7'h06, 8'h00);
    wr(7'h07, 8'h02);
    for (int i = 4; i >= 0; i--) begin
      tick_and_settle();
      expect_v("t4_down", 32'(i)); chk(duty);
    end
    expect_v("t4_down_done", 1); chk(done);

    // Abort a ramp mid-way
    set_duty(8'h00);
    wr(7'h05, 8'hFF);
    wr(7'h06, 8'h01);
    wr(7'h07, 8'h02);
    repeat (3) tick_and_settle();
    expect_v("t5_three", 8'h03); chk(duty);
    wr(7'h07, 8'h04);
    expect_v("t5_abort_busy", 0); chk(busy);
    wr(7'h04, 8'h77);
    wr(7'h07, 8'h01);
    wr(7'h07, 8'h04);
    expect_v("t5_cancel_busy", 0); chk(busy);
    tick_and_settle();
    expect_v("t5_hold", 8'h03); chk(duty);
    expect_v("t5_nodone", 0);   chk(done);

    // COMMIT written on the tick cycle
    wr(7'h04, 8'h55);
    wait_tick();
    wr_bus.wr_valid = 1'b1;
    wr_bus.wr_addr  = 7'h07;
    wr_bus.wr_data  = 8'h01;
    @(negedge clk);
    wr_bus.wr_valid = 1'b0;
    expect_v("t5_late_duty", 8'h03); chk(duty);
    expect_v("t5_late_busy", 1);     chk(busy);
    tick_and_settle();
    expect_v("t5_late_apply", 8'h55); chk(duty);

    // Commit + start: duty ramps from active value
    wr(7'h04, 8'hAA);
    wr(7'h00, 8'h3C);
    wr(7'h05, 8'hFF);
    wr(7'h06, 8'h01);
    wr(7'h07, 8'h03);
    tick_and_settle();
    expect_v("t6_ramp", 8'h56);   chk(duty);
    expect_v("t6_en", 8'h3C);     chk(en_out_lo);
    wr(7'h00, 8'hC3);
    wr(7'h07, 8'h01);
    expect_v("t6_busy", 1); chk(busy);

    // Asynchronous reset mid-ramp
    #2 rst_n = 1'b0;
    #1;
    expect_v("t6_rst_duty", 0); chk(duty);
    expect_v("t6_rst_en", 0);   chk(en_out_lo);
    expect_v("t6_rst_busy", 0); chk(busy);
    expect_v("t6_rst_done", 0); chk(done);
    @(negedge clk);
    rst_n = 1'b1;
    expect_v("t6_tick0", 255);
    wait_tick(); chk(cyc);
    @(negedge clk);
    expect_v("t6_no_commit", 0); chk(en_out_lo);
    expect_v("t6_no_ramp", 0);   chk(duty);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
